// File: rtl/led_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl_pkg
// Shared definitions for the RGB LED sequencer:
//   - state_t        : sequencer FSM encoding (IDLE / RUN / DONE)
//   - pattern_t      : one pattern table entry {rgb, dwell ticks}
//   - PATTERN_TABLE  : fixed 8-step colour sequence (read-only constant)
//   - STEP_W/DWELL_W : widths of the step index and dwell counter
//   - pattern_at()   : constant lookup helper into PATTERN_TABLE
// -----------------------------------------------------------------------------
package led_seq_ctrl_pkg;

    localparam int STEP_W    = 3;
    localparam int DWELL_W   = 4;
    localparam int NUM_STEPS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // rgb[2] = red, rgb[1] = green, rgb[0] = blue
    typedef struct packed {
        logic [2:0]         rgb;
        logic [DWELL_W-1:0] dwell;
    } pattern_t;

    localparam pattern_t PATTERN_TABLE [NUM_STEPS] = '{
        '{rgb: 3'b100, dwell: 4'd5},
        '{rgb: 3'b010, dwell: 4'd5},
        '{rgb: 3'b001, dwell: 4'd5},
        '{rgb: 3'b110, dwell: 4'd3},
        '{rgb: 3'b011, dwell: 4'd3},
        '{rgb: 3'b101, dwell: 4'd3},
        '{rgb: 3'b111, dwell: 4'd2},
        '{rgb: 3'b000, dwell: 4'd2}
    };

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    function automatic pattern_t pattern_at(input logic [STEP_W-1:0] step);
        return PATTERN_TABLE[step];
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl_if
// Control/status bundle of the LED sequencer.
//   i_start, i_abort, i_loop : requests into the sequencer
//   o_busy, o_done, o_step   : sequencer status
//   o_led_r/g/b              : active-high LED drive
// master: the controlling side (drives requests); slave: the sequencer.
// -----------------------------------------------------------------------------
interface led_seq_ctrl_if;
    import led_seq_ctrl_pkg::*;

    logic              i_start;
    logic              i_abort;
    logic              i_loop;
    logic              o_busy;
    logic              o_done;
    logic [STEP_W-1:0] o_step;
    logic              o_led_r;
    logic              o_led_g;
    logic              o_led_b;

    modport master (
        output i_start, i_abort, i_loop,
        input  o_busy, o_done, o_step, o_led_r, o_led_g, o_led_b
    );

    modport slave (
        input  i_start, i_abort, i_loop,
        output o_busy, o_done, o_step, o_led_r, o_led_g, o_led_b
    );

endinterface

// File: rtl/led_seq_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler: counts 0..P_DIV-1 while enabled and flags o_tick in the cycle
// the count sits at P_DIV-1. When disabled the count is forced back to 0, so
// every enabled stretch starts a fresh period.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   i_en   : count enable
//   o_tick : one-cycle tick every P_DIV enabled cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int P_DIV = 1_200_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int                CNT_W   = $clog2(P_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        o_tick   = i_en && (cnt_reg == CNT_MAX);
        cnt_next = cnt_reg + CNT_W'(1);
        if (!i_en || o_tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
// RGB LED pattern sequencer. On start it walks the 8-entry pattern table,
// holding each colour for dwell * P_DIV clocks, then either pulses o_done for
// one cycle or (loop mode) wraps back to step 0. Abort returns to IDLE.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : led_seq_ctrl_if.slave (start/abort/loop in; busy/done/step/LEDs out)
// -----------------------------------------------------------------------------
module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
#(
    parameter int P_DIV = 1_200_000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    led_seq_ctrl_if.slave  bus
);

    state_t              state_reg, state_next;
    logic [STEP_W-1:0]   step_reg,  step_next;
    logic [DWELL_W-1:0]  dwell_reg, dwell_next;
    logic                loop_reg,  loop_next;

    logic                is_run;
    logic                tick;
    logic [STEP_W-1:0]   step_inc;
    pattern_t            cur_pat;
    logic [2:0]          led_vec;

    assign is_run   = (state_reg == ST_RUN);
    assign step_inc = step_reg + STEP_W'(1);

    // Gating the prescaler with abort keeps the count at 0 from the very
    // first cycle back in IDLE.
    tick_gen #(
        .P_DIV (P_DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (is_run && !bus.i_abort),
        .o_tick (tick)
    );

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        dwell_next = dwell_reg;
        loop_next  = loop_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_abort) begin
                    state_next = ST_RUN;
                    step_next  = '0;
                    dwell_next = pattern_at('0).dwell;
                    loop_next  = bus.i_loop;
                end
            end
            ST_RUN: begin
                if (bus.i_abort) begin
                    state_next = ST_IDLE;
                    step_next  = '0;
                    dwell_next = '0;
                end else if (tick) begin
                    if (dwell_reg > DWELL_W'(1)) begin
                        dwell_next = dwell_reg - DWELL_W'(1);
                    end else if (step_reg != LAST_STEP) begin
                        step_next  = step_inc;
                        dwell_next = pattern_at(step_inc).dwell;
                    end else if (loop_reg) begin
                        step_next  = '0;
                        dwell_next = pattern_at('0).dwell;
                    end else begin
                        state_next = ST_DONE;
                        step_next  = '0;
                        dwell_next = '0;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            step_reg  <= '0;
            dwell_reg <= '0;
            loop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            dwell_reg <= dwell_next;
            loop_reg  <= loop_next;
        end
    end

    // Outputs are decoded straight from the registered state: no extra latency.
    assign cur_pat = pattern_at(step_reg);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_led
            assign led_vec[gi] = is_run & cur_pat.rgb[gi];
        end
    endgenerate

    assign bus.o_busy  = is_run;
    assign bus.o_done  = (state_reg == ST_DONE);
    assign bus.o_step  = is_run ? step_reg : '0;
    assign bus.o_led_r = led_vec[2];
    assign bus.o_led_g = led_vec[1];
    assign bus.o_led_b = led_vec[0];

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
// Directed bench for led_seq_ctrl with P_DIV=4. Cycle c is the interval after
// the clock edge that follows cycle c-1; a start accepted at the edge ending
// cycle 0 makes cycle 1 the first RUN cycle.
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;

    localparam int P_DIV = 4;

    typedef struct {
        int         cycle;
        logic       busy;
        logic       done;
        logic [2:0] step;
        logic [2:0] rgb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    led_seq_ctrl_if bus ();

    led_seq_ctrl #(
        .P_DIV (P_DIV)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic busy, input logic done,
                              input logic [2:0] step, input logic [2:0] rgb);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'(busy));
        check({tag, "_done"}, 32'(bus.o_done), 32'(done));
        check({tag, "_step"}, 32'(bus.o_step), 32'(step));
        check({tag, "_rgb"},  32'({bus.o_led_r, bus.o_led_g, bus.o_led_b}), 32'(rgb));
        $display("[TB] %s: busy=%0b done=%0b step=%0d rgb=%03b", tag,
                 bus.o_busy, bus.o_done, bus.o_step, {bus.o_led_r, bus.o_led_g, bus.o_led_b});
    endtask

    task automatic add_vec(input int c, input logic b, input logic d,
                           input logic [2:0] s, input logic [2:0] r);
        vec_t v;
        v.cycle = c; v.busy = b; v.done = d; v.step = s; v.rgb = r;
        vecs.push_back(v);
    endtask

    initial begin
        int vi, done_cnt, busy_cnt, done_cyc, first_busy;

        // Single-shot checkpoints: step boundaries at cycles 20,40,60,72,84,96,104,112.
        add_vec(  1, 1, 0, 3'd0, 3'b100);
        add_vec( 20, 1, 0, 3'd0, 3'b100);
        add_vec( 21, 1, 0, 3'd1, 3'b010);
        add_vec( 40, 1, 0, 3'd1, 3'b010);
        add_vec( 41, 1, 0, 3'd2, 3'b001);
        add_vec( 60, 1, 0, 3'd2, 3'b001);
        add_vec( 61, 1, 0, 3'd3, 3'b110);
        add_vec( 72, 1, 0, 3'd3, 3'b110);
        add_vec( 73, 1, 0, 3'd4, 3'b011);
        add_vec( 85, 1, 0, 3'd5, 3'b101);
        add_vec( 97, 1, 0, 3'd6, 3'b111);
        add_vec(104, 1, 0, 3'd6, 3'b111);
        add_vec(105, 1, 0, 3'd7, 3'b000);
        add_vec(112, 1, 0, 3'd7, 3'b000);
        add_vec(113, 0, 1, 3'd0, 3'b000);

        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_loop  = 1'b0;

        // Reset, with start held high to show reset wins.
        rst = 1'b1;
        bus.i_start = 1'b1;
        tick();
        tick();
        check_outs("reset", 0, 0, 3'd0, 3'b000);
        bus.i_start = 1'b0;
        rst = 1'b0;
        tick();
        check_outs("post_reset", 0, 0, 3'd0, 3'b000);

        // Single shot, with a stray start pulse at cycle 50.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        vi = 0; done_cnt = 0; busy_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 113; c++) begin
            if (bus.o_done) begin done_cnt++; done_cyc = c; end
            if (bus.o_busy) busy_cnt++;
            if (vi < vecs.size() && vecs[vi].cycle == c) begin
                check_outs($sformatf("single_c%0d", c), vecs[vi].busy, vecs[vi].done,
                           vecs[vi].step, vecs[vi].rgb);
                vi++;
            end
            bus.i_start = (c == 50);
            tick();
        end
        bus.i_start = 1'b0;
        check_outs("single_c114", 0, 0, 3'd0, 3'b000);
        check("single_busy_cycles", busy_cnt, 112);
        check("single_done_count", done_cnt, 1);
        check("single_done_cycle", done_cyc, 113);

        // Start and abort together in IDLE: stay idle.
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        check_outs("collide_c1", 0, 0, 3'd0, 3'b000);
        tick();
        check_outs("collide_c2", 0, 0, 3'd0, 3'b000);

        // Loop mode; i_loop dropped during the run must not matter.
        bus.i_loop  = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_loop  = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 113; c++) begin
            if (bus.o_done) done_cnt++;
            if (c == 112) check_outs("loop_c112", 1, 0, 3'd7, 3'b000);
            if (c == 113) check_outs("loop_c113", 1, 0, 3'd0, 3'b100);
            bus.i_abort = (c == 113);
            tick();
        end
        bus.i_abort = 1'b0;
        check_outs("loop_abort_c114", 0, 0, 3'd0, 3'b000);
        check("loop_done_count", done_cnt, 0);

        // Abort at cycle 30 (step 1).
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 30) check_outs("abort_c30", 1, 0, 3'd1, 3'b010);
            bus.i_abort = (c == 30);
            tick();
        end
        bus.i_abort = 1'b0;
        check_outs("abort_c31", 0, 0, 3'd0, 3'b000);
        done_cnt = 0; busy_cnt = 0;
        for (int c = 31; c <= 150; c++) begin
            if (bus.o_done) done_cnt++;
            if (bus.o_busy) busy_cnt++;
            tick();
        end
        check("abort_done_count", done_cnt, 0);
        check("abort_busy_after", busy_cnt, 0);

        // Reset mid-run at cycle 60, restart at cycle 70.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            rst = (c == 60);
            tick();
        end
        rst = 1'b0;
        check_outs("midrst_c61", 0, 0, 3'd0, 3'b000);
        for (int c = 61; c <= 70; c++) begin
            bus.i_start = (c == 70);
            tick();
        end
        bus.i_start = 1'b0;
        first_busy = -1; busy_cnt = 0; done_cyc = -1; done_cnt = 0;
        for (int c = 71; c <= 190; c++) begin
            if (bus.o_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
            end
            if (bus.o_done) begin done_cnt++; done_cyc = c; end
            if (c == 71) check_outs("midrst_c71", 1, 0, 3'd0, 3'b100);
            tick();
        end
        check("midrst_first_busy", first_busy, 71);
        check("midrst_busy_cycles", busy_cnt, 112);
        check("midrst_done_count", done_cnt, 1);
        check("midrst_done_cycle", done_cyc, 183);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
